// File: rtl/axil2apb_bridge.sv
// AXI4-Lite slave to APB master bridge with a single APB transfer in flight.
// Read/write contention is resolved by alternating priority.
module axil2apb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ADDR_W-1:0]   s_araddr,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                m_pclk,
  output logic                m_preset,
  output logic [ADDR_W-1:0]   m_paddr,
  output logic                m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [DATA_W-1:0]   m_pwdata,
  output logic [DATA_W/8-1:0] m_pwstrb,
  input  logic                m_pready,
  input  logic                m_pslverr,
  input  logic [DATA_W-1:0]   m_prdata
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_wr_q, last_wr_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pwstrb_q, pwstrb_d;
  logic                bvalid_q, bvalid_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic wr_req, rd_req, grant_wr, grant_rd, idle_ok, finish;

  assign wr_req   = s_awvalid & s_wvalid;
  assign rd_req   = s_arvalid;
  // last_wr=1 hands the tie to the read side, so winners alternate under contention.
  assign grant_wr = wr_req & (~rd_req | ~last_wr_q);
  assign grant_rd = rd_req & (~wr_req | last_wr_q);
  assign idle_ok  = (state_q == IDLE) & ~preset;

  assign s_awready = idle_ok & grant_wr;
  assign s_wready  = idle_ok & grant_wr;
  assign s_arready = idle_ok & grant_rd;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pwstrb_d  = pwstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_wr | grant_rd) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = grant_wr ? s_awaddr : s_araddr;
          pwrite_d  = grant_wr;
          pwdata_d  = grant_wr ? s_wdata : '0;
          pwstrb_d  = grant_wr ? s_wstrb : '0;
          last_wr_d = grant_wr;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (m_pready) begin
          finish = 1'b1;
          resp_d = m_pslverr ? 2'b10 : 2'b00;
          if (!pwrite_q) rdata_d = m_prdata;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          finish  = 1'b1;
          resp_d  = 2'b10;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (finish) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          bvalid_d  = pwrite_q;
          rvalid_d  = ~pwrite_q;
        end
      end
      RESP: begin
        if ((bvalid_q & s_bready) | (rvalid_q & s_rready)) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
          resp_d   = 2'b00;
          rdata_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pwstrb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      resp_q    <= 2'b00;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pwstrb_q  <= pwstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_pclk    = pclk;
  assign m_preset  = preset;
  assign m_paddr   = paddr_q;
  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign m_pwrite  = pwrite_q;
  assign m_pwdata  = pwdata_q;
  assign m_pwstrb  = pwstrb_q;
  assign s_bvalid  = bvalid_q;
  assign s_rvalid  = rvalid_q;
  assign s_bresp   = bvalid_q ? resp_q : 2'b00;
  assign s_rresp   = rvalid_q ? resp_q : 2'b00;
  assign s_rdata   = rdata_q;
endmodule

// File: tb/tb_axil2apb_bridge.sv
// Directed and randomized checks of axil2apb_bridge against a transaction-level model:
// a word memory behind an APB slave, an alternating-priority bit and a timeout rule.
module tb_axil2apb_bridge;
  localparam int TO = 8;

  logic        pclk = 1'b0;
  logic        preset;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        m_pclk, m_preset, m_psel, m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata;
  logic [3:0]  m_pwstrb;
  logic        m_pready, m_pslverr;
  logic [31:0] m_prdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [logic [31:0]];
  bit last_wr_m;

  axil2apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_pclk(m_pclk), .m_preset(m_preset), .m_paddr(m_paddr), .m_psel(m_psel),
    .m_penable(m_penable), .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = model_rd(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mem[a] = w;
  endtask

  task automatic set_valids(input logic v);
    s_awvalid = v; s_wvalid = v; s_arvalid = v;
  endtask

  // Called at posedge+1 with valids already driven; returns at the negedge of the accept cycle.
  task automatic do_accept(input bit wr, output bit ok);
    ok = 1'b0;
    @(negedge pclk);
    chk("idle_psel", 32'(m_psel), 0);
    chk("idle_valid", 32'({s_bvalid, s_rvalid}), 0);
    chk("idle_rdata", s_rdata, 0);
    for (int c = 0; c < 16; c++) begin
      if (wr ? s_awready : s_arready) begin
        ok = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    chk("accept", 32'(ok), 1);
    if (ok) begin
      chk("wready", 32'(s_wready), 32'(wr));
      chk("loser_ready", 32'(wr ? s_arready : s_awready), 0);
      last_wr_m = wr;
    end
  endtask

  task automatic finish_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int waits, input bit err,
                             input int hold, input bit poke);
    bit          to;
    int          acc_len;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
    to       = (TO != 0) && (waits >= TO);
    acc_len  = to ? TO : waits + 1;
    exp_resp = (to || err) ? 2'b10 : 2'b00;
    exp_rd   = (wr || to) ? 32'h0 : model_rd(addr);
    $display("xfer %s addr=%h data=%h strb=%h waits=%0d err=%0d hold=%0d resp=%0d",
             wr ? "WR" : "RD", addr, data, strb, waits, err, hold, exp_resp);
    @(posedge pclk); #1;
    if (wr) begin s_awvalid = 0; s_wvalid = 0; end else s_arvalid = 0;
    m_pready = 1'b1; m_pslverr = 1'b1; m_prdata = $urandom;
    @(negedge pclk);
    chk("setup_psel", 32'(m_psel), 1);
    chk("setup_penable", 32'(m_penable), 0);
    chk("setup_paddr", m_paddr, addr);
    chk("setup_pwrite", 32'(m_pwrite), 32'(wr));
    chk("setup_pwdata", m_pwdata, wr ? data : 32'h0);
    chk("setup_pwstrb", 32'(m_pwstrb), wr ? 32'(strb) : 0);
    chk("setup_valid", 32'({s_bvalid, s_rvalid}), 0);
    for (int i = 0; i < acc_len; i++) begin
      @(posedge pclk); #1;
      m_pready  = (i == waits);
      m_pslverr = err;
      m_prdata  = wr ? $urandom : model_rd(addr);
      @(negedge pclk);
      chk("access_psel_penable", 32'({m_psel, m_penable}), 3);
      chk("access_paddr", m_paddr, addr);
      chk("access_valid", 32'({s_bvalid, s_rvalid}), 0);
    end
    @(posedge pclk); #1;
    m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = $urandom;
    if (poke) set_valids(1'b1);
    for (int k = 0; k <= hold; k++) begin
      if (k == hold) begin
        s_bready = 1'b1; s_rready = 1'b1;
        if (poke) set_valids(1'b0);
      end
      @(negedge pclk);
      chk("resp_psel", 32'({m_psel, m_penable}), 0);
      chk("resp_bvalid", 32'(s_bvalid), 32'(wr));
      chk("resp_rvalid", 32'(s_rvalid), 32'(!wr));
      chk("resp_code", 32'(wr ? s_bresp : s_rresp), 32'(exp_resp));
      chk("resp_other_code", 32'(wr ? s_rresp : s_bresp), 0);
      chk("resp_rdata", s_rdata, exp_rd);
      chk("resp_no_accept", 32'({s_awready, s_wready, s_arready}), 0);
      if (k != hold) begin @(posedge pclk); #1; end
    end
    @(posedge pclk); #1;
    s_bready = 1'b0; s_rready = 1'b0;
    if (wr && !to && !err) model_wr(addr, data, strb);
  endtask

  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int waits, input bit err,
                         input int hold, input bit poke);
    bit ok;
    if (wr) begin
      s_awaddr = addr; s_wdata = data; s_wstrb = strb; s_awvalid = 1; s_wvalid = 1;
    end else begin
      s_araddr = addr; s_arvalid = 1;
    end
    do_accept(wr, ok);
    if (ok) finish_xfer(wr, addr, data, strb, waits, err, hold, poke);
    else begin @(posedge pclk); #1; set_valids(1'b0); end
  endtask

  task automatic contend(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
    bit ok;
    bit first;
    first = !last_wr_m;
    s_awaddr = wa; s_wdata = wd; s_wstrb = 4'hF; s_araddr = ra;
    set_valids(1'b1);
    do_accept(first, ok);
    if (ok) finish_xfer(first, first ? wa : ra, wd, 4'hF, 0, 0, 1, 0);
    do_accept(!first, ok);
    if (ok) finish_xfer(!first, first ? ra : wa, wd, 4'hF, 0, 0, 1, 0);
    set_valids(1'b0);
  endtask

  initial begin
    bit ok;
    preset = 1; last_wr_m = 1;
    set_valids(1'b1);
    s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0;
    s_bready = 0; s_rready = 0; m_pready = 0; m_pslverr = 0; m_prdata = 0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_ready", 32'({s_awready, s_wready, s_arready}), 0);
    chk("rst_apb", 32'({m_psel, m_penable, m_pwrite}), 0);
    chk("rst_paddr", m_paddr, 0);
    chk("rst_pwdata", m_pwdata, 0);
    chk("rst_pwstrb", 32'(m_pwstrb), 0);
    chk("rst_valid", 32'({s_bvalid, s_rvalid}), 0);
    chk("rst_resp", 32'({s_bresp, s_rresp}), 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_m_preset", 32'(m_preset), 1);
    @(posedge pclk); #1;
    set_valids(1'b0); preset = 0;

    // Contention straight out of reset: read first, then write.
    contend(32'h0000_4000, 32'hA5A5_0001, 32'h0000_4000);
    // Minimum-latency write, then a read with two wait states.
    do_xfer(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
    do_xfer(1, 32'h0000_2004, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
    do_xfer(0, 32'h0000_2004, 32'h0, 4'h0, 2, 0, 0, 0);
    // Last grant was a read, so contention now favours the write.
    contend(32'h0000_4004, 32'h0BAD_F00D, 32'h0000_4004);
    // Slave error on a write with a stalled response channel.
    do_xfer(1, 32'h0000_2004, 32'hFFFF_FFFF, 4'hF, 0, 1, 5, 1);
    do_xfer(0, 32'h0000_2004, 32'h0, 4'h0, 0, 0, 0, 0);
    // Stuck pready on a read: timeout error with zero data.
    do_xfer(0, 32'h0000_2004, 32'h0, 4'h0, 20, 0, 0, 0);
    do_xfer(1, 32'h0000_2004, 32'h0000_00C3, 4'h1, 7, 0, 0, 0);
    do_xfer(0, 32'h0000_2004, 32'h0, 4'h0, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int r;
      int w;
      r = $urandom_range(0, 9);
      w = (r < 7) ? r % 3 : ((r == 7) ? 4 : 10);
      do_xfer($urandom_range(0, 1) == 1, 32'h3000 + 32'($urandom_range(0, 7)) * 4, $urandom,
              4'($urandom_range(1, 15)), w, $urandom_range(0, 4) == 0,
              $urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end

    // Reset in the middle of an ACCESS phase drops the write.
    s_awaddr = 32'h0000_5000; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    do_accept(1, ok);
    @(posedge pclk); #1;
    set_valids(1'b0);
    repeat (3) begin @(posedge pclk); #1; end
    preset = 1; set_valids(1'b1);
    @(negedge pclk);
    chk("rst_mid_ready", 32'({s_awready, s_wready, s_arready}), 0);
    chk("rst_mid_m_preset", 32'(m_preset), 1);
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("rst_mid_apb", 32'({m_psel, m_penable}), 0);
    chk("rst_mid_valid", 32'({s_bvalid, s_rvalid}), 0);
    chk("rst_mid_ready2", 32'({s_awready, s_wready, s_arready}), 0);
    @(posedge pclk); #1;
    preset = 0; set_valids(1'b0); last_wr_m = 1;
    s_bready = 1; s_rready = 1;
    repeat (4) begin
      @(negedge pclk);
      chk("rst_mid_no_resp", 32'({s_bvalid, s_rvalid, m_psel}), 0);
    end
    @(posedge pclk); #1;
    s_bready = 0; s_rready = 0;
    // Dropped write must not have landed; priority restarts with read first.
    contend(32'h0000_5000, 32'h1111_2222, 32'h0000_5000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
